core_irq_controller_fsm: RTL and testbench
==========================================

// Module: core_irq_controller_fsm
// PURPOSE
//   Next-generation core controller: run-control FSM plus a machine-mode CSR subset with NUM_IRQ prioritised interrupt lines.
//   Sits beside the RV32I pipeline; gates the design enable, sequences trap entry and mret, and supplies the handler vector.
//   Generalises the single-timer controller to N sources with mcause, correct MIE/MPIE stacking and per-line acks.
// PARAMETERS
//   XLEN        32   data/PC width
//   CSR_AW      12   CSR address width
//   NUM_IRQ     3    interrupt lines, 1..16
// PORTS
//   clk                        in   1        clock
//   reset                      in   1        sync active-high reset
//   control_signal             in   XLEN     [0] start, [1] reset_request, [2] rst_force
//   end_condition              in   1        program end detected
//   all_ready                  in   1        pipeline drained after flush
//   ready_for_irq_handler      in   1        pipeline quiesced for trap entry
//   irq_lines                  in   NUM_IRQ  level interrupt requests
//   pc_stage_2, nextPC_o       in   XLEN     stage-2 PC / redirect target
//   change_PC_condition_for_jump_or_branch in 1  redirect taken in stage 2
//   mret_inst                  in   1        mret retiring
//   write_csr                  in   1        CSR write strobe
//   csr_wr_addr / csr_rd_addr  in   CSR_AW   write / read address
//   csr_wr_data                in   XLEN     write data
//   csr_rd_data                out  XLEN     read data, combinational
//   enable_design              out  1        state != IDLE
//   program_finished           out  1        state == DONE
//   irq_prep                   out  1        state == PARTIAL_IRQ
//   interrupt_vector_o         out  XLEN     handler address
//   mepc_o, mcause_o           out  XLEN     current mepc / mcause
//   irq_ack_o                  out  NUM_IRQ  one-hot, 1-cycle pulse on trap entry
// BEHAVIOUR
//   - Reset: state=IDLE; all CSRs 0; all outputs 0 except csr_rd_data (reflects CSRs).
//   - control_signal[2] acts as reset for the FSM only; CSRs are unaffected.
//   - Implemented CSRs: mstatus 0x300 (MIE b3, MPIE b7), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
//   - Unimplemented CSRs read 0 and ignore writes. mip is read-only.
//   - mip is the live view of irq_lines.
//   - Line i maps to mie/mip bit B(i): B = 3, 7, 11 for i = 0..2; B = 16 + i - 3 for i >= 3.
//   - Read forwarding: if write_csr and wr_addr == rd_addr, csr_rd_data = csr_wr_data (masked to implemented bits).
//   - pending = irq_lines & mie bits; take = mstatus.MIE & |pending. Priority: highest line index wins.
//   - FSM states and transitions:
//       IDLE -> PROGRAM on start.
//       PROGRAM: reset_request -> FULL_FLUSH_RESET; else take -> PARTIAL_IRQ (latch winner idx);
//                else end_condition -> DONE.
//       PARTIAL_IRQ: reset_request -> FFR; else ready_for_irq_handler -> IRQ_HANDLE.
//       IRQ_HANDLE: reset_request -> FFR; else mret_inst -> PROGRAM.
//       FULL_FLUSH_RESET: all_ready -> IDLE. DONE: reset_request -> FFR.
//       Illegal state -> IDLE.
//   - Trap entry (PARTIAL_IRQ & ready, same edge as transition):
//       mepc <= redirect ? nextPC_o : pc_stage_2 + 4;
//       mcause <= {1'b1, B(latched idx)};
//       MPIE <= MIE; MIE <= 0;
//       irq_ack_o[idx] = 1 for that cycle.
//   - mret in IRQ_HANDLE: MIE <= MPIE; MPIE <= 1.
//   - Trap update beats a same-cycle write_csr to the same CSR. Writes to other CSRs still land.
//   - Winner is latched on entering PARTIAL_IRQ. Lines dropping afterwards do not cancel the trap.
//   - No nesting: irq_lines are ignored outside PROGRAM.
//   - reset_request in PARTIAL_IRQ cancels trap entry: no CSR update, no ack.
//   - PC arithmetic is modulo 2^XLEN (pc+4 wraps).
// CONFIGURATION
//   IRQ_VECTORED_EN defined:
//     - mtvec[1:0] is writable.
//     - mode==1: vector = {base,2'b00} + 4*B(idx).
//     - Any other mode: vector = {base,2'b00}.
//   IRQ_VECTORED_EN undefined:
//     - mtvec[1:0] is forced to 0 on write and reads 0.
//     - Vector is always {base,2'b00}.
// TESTING
//   - reset=1 one cycle, then start -> enable_design=1 next cycle; CSR 0x300 reads 0.
//   - mie=0x80, mstatus=0x8, irq_lines=3'b010, pc_stage_2=0x100, no redirect, ready=1
//     -> mepc=0x104, mcause=0x80000007, mstatus=0x80, irq_ack_o=010.
//   - Lines 0 and 2 both pending and enabled -> mcause=0x8000000B, ack=100.
//   - mret in IRQ_HANDLE -> state PROGRAM, mstatus=0x88.
//   - With IRQ_VECTORED_EN: mtvec=0x1001, timer trap -> interrupt_vector_o=0x101C.
//     Without the macro: mtvec reads 0x1000, vector=0x1000.
//   - reset_request during PARTIAL_IRQ -> FULL_FLUSH_RESET, mepc unchanged;
//     all_ready -> IDLE. write_csr 0x341 on trap edge -> trap value kept.

Source files
------------

// File: rtl/core_irq_controller_fsm.sv
// Core run-control FSM with a machine-mode CSR subset and NUM_IRQ prioritised interrupt lines.
// Sequences trap entry / mret, keeps mepc/mcause/mstatus stacking, and supplies the handler
// vector. Optional macro IRQ_VECTORED_EN enables vectored mtvec mode (mtvec[1:0] == 1).
module core_irq_controller_fsm #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned NUM_IRQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    control_signal,
  input  logic               end_condition,
  input  logic               all_ready,
  input  logic               ready_for_irq_handler,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [XLEN-1:0]    pc_stage_2,
  input  logic [XLEN-1:0]    nextPC_o,
  input  logic               change_PC_condition_for_jump_or_branch,
  input  logic               mret_inst,
  input  logic               write_csr,
  input  logic [CSR_AW-1:0]  csr_wr_addr,
  input  logic [CSR_AW-1:0]  csr_rd_addr,
  input  logic [XLEN-1:0]    csr_wr_data,
  output logic [XLEN-1:0]    csr_rd_data,
  output logic               enable_design,
  output logic               program_finished,
  output logic               irq_prep,
  output logic [XLEN-1:0]    interrupt_vector_o,
  output logic [XLEN-1:0]    mepc_o,
  output logic [XLEN-1:0]    mcause_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [CSR_AW-1:0] AddrMstatus = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] AddrMie     = CSR_AW'(12'h304);
  localparam logic [CSR_AW-1:0] AddrMtvec   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] AddrMepc    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] AddrMcause  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] AddrMip     = CSR_AW'(12'h344);

  localparam logic [XLEN-1:0] MstatusMask = XLEN'(32'h88);
`ifdef IRQ_VECTORED_EN
  localparam logic [XLEN-1:0] MtvecMask = '1;
`else
  localparam logic [XLEN-1:0] MtvecMask = {{(XLEN-2){1'b1}}, 2'b00};
`endif

  typedef enum logic [2:0] {
    StIdle, StProgram, StPartialIrq, StIrqHandle, StFullFlushReset, StDone
  } state_e;

  // Line i -> mie/mip bit: 3, 7, 11 for lines 0..2, then 16 + i - 3.
  function automatic logic [4:0] irq_bit(input int i);
    if (i < 3) irq_bit = 5'(3 + 4 * i);
    else       irq_bit = 5'(i + 13);
  endfunction

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d, winner;
  logic [NUM_IRQ-1:0]   ack_q, ack_d, pending;
  logic                 enable_design_q, enable_design_d;
  logic                 program_finished_q, program_finished_d;
  logic                 irq_prep_q, irq_prep_d;
  logic [XLEN-1:0]      mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0]      mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0]      mie_mask, mip_live, vec_base;
  logic                 start, reset_request, rst_force, take, trap_entry, mret_fire;
  logic                 unused_ctrl;

  assign start         = control_signal[0];
  assign reset_request = control_signal[1];
  assign rst_force     = control_signal[2];
  assign unused_ctrl   = ^control_signal[XLEN-1:3];

  // Map lines onto CSR bit positions and pick the highest-index enabled pending line.
  always_comb begin
    pending  = '0;
    mie_mask = '0;
    mip_live = '0;
    winner   = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      mie_mask[irq_bit(i)] = 1'b1;
      mip_live[irq_bit(i)] = irq_lines[i];
      pending[i]           = irq_lines[i] & mie_q[irq_bit(i)];
      if (pending[i]) winner = IdxW'(i);
    end
  end

  assign take       = mstatus_q[3] & (|pending);
  // A reset request (or forced FSM reset) in the same cycle cancels the CSR side effects.
  assign trap_entry = (state_q == StPartialIrq) & ready_for_irq_handler & ~reset_request &
                      ~rst_force;
  assign mret_fire  = (state_q == StIrqHandle) & mret_inst & ~reset_request & ~rst_force;

  // Next-state, winner latch and registered-output next values.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:           if (start) state_d = StProgram;
      StProgram: begin
        if (reset_request)      state_d = StFullFlushReset;
        else if (take)          state_d = StPartialIrq;
        else if (end_condition) state_d = StDone;
      end
      StPartialIrq: begin
        if (reset_request)              state_d = StFullFlushReset;
        else if (ready_for_irq_handler) state_d = StIrqHandle;
      end
      StIrqHandle: begin
        if (reset_request)  state_d = StFullFlushReset;
        else if (mret_inst) state_d = StProgram;
      end
      StFullFlushReset: if (all_ready) state_d = StIdle;
      StDone:           if (reset_request) state_d = StFullFlushReset;
      default:          state_d = StIdle;
    endcase
    if (rst_force) state_d = StIdle;

    idx_d = idx_q;
    if (state_q == StProgram && state_d == StPartialIrq) idx_d = winner;

    ack_d = '0;
    if (trap_entry) ack_d[idx_q] = 1'b1;

    enable_design_d    = (state_d != StIdle);
    program_finished_d = (state_d == StDone);
    irq_prep_d         = (state_d == StPartialIrq);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      idx_q              <= '0;
      ack_q              <= '0;
      enable_design_q    <= 1'b0;
      program_finished_q <= 1'b0;
      irq_prep_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      ack_q              <= ack_d;
      enable_design_q    <= enable_design_d;
      program_finished_q <= program_finished_d;
      irq_prep_q         <= irq_prep_d;
    end
  end

  // CSR next values: software writes first, trap/mret updates override them.
  always_comb begin
    mstatus_d = mstatus_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (write_csr) begin
      case (csr_wr_addr)
        AddrMstatus: mstatus_d = csr_wr_data & MstatusMask;
        AddrMie:     mie_d     = csr_wr_data & mie_mask;
        AddrMtvec:   mtvec_d   = csr_wr_data & MtvecMask;
        AddrMepc:    mepc_d    = csr_wr_data;
        AddrMcause:  mcause_d  = csr_wr_data;
        default:     ;
      endcase
    end
    if (trap_entry) begin
      mepc_d       = change_PC_condition_for_jump_or_branch ? nextPC_o
                                                            : pc_stage_2 + XLEN'(4);
      mcause_d     = {1'b1, {(XLEN-6){1'b0}}, irq_bit(int'(idx_q))};
      mstatus_d    = '0;
      mstatus_d[7] = mstatus_q[3];
    end
    if (mret_fire) begin
      mstatus_d    = '0;
      mstatus_d[3] = mstatus_q[7];
      mstatus_d[7] = 1'b1;
    end
  end

  // CSR storage; unaffected by the FSM-only forced reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Read mux with same-cycle write forwarding (mip and unimplemented addresses never forward).
  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      AddrMstatus: csr_rd_data = mstatus_q;
      AddrMie:     csr_rd_data = mie_q;
      AddrMtvec:   csr_rd_data = mtvec_q;
      AddrMepc:    csr_rd_data = mepc_q;
      AddrMcause:  csr_rd_data = mcause_q;
      AddrMip:     csr_rd_data = mip_live;
      default:     csr_rd_data = '0;
    endcase
    if (write_csr && (csr_wr_addr == csr_rd_addr)) begin
      case (csr_rd_addr)
        AddrMstatus: csr_rd_data = csr_wr_data & MstatusMask;
        AddrMie:     csr_rd_data = csr_wr_data & mie_mask;
        AddrMtvec:   csr_rd_data = csr_wr_data & MtvecMask;
        AddrMepc:    csr_rd_data = csr_wr_data;
        AddrMcause:  csr_rd_data = csr_wr_data;
        default:     ;
      endcase
    end
  end

  assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};

  // Handler vector from mtvec and the latched winner.
  always_comb begin
`ifdef IRQ_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01) begin
      interrupt_vector_o = vec_base + XLEN'({irq_bit(int'(idx_q)), 2'b00});
    end else begin
      interrupt_vector_o = vec_base;
    end
`else
    interrupt_vector_o = vec_base;
`endif
  end

`ifndef IRQ_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_q[1:0];
`endif

  assign enable_design    = enable_design_q;
  assign program_finished = program_finished_q;
  assign irq_prep         = irq_prep_q;
  assign irq_ack_o        = ack_q;
  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;

endmodule

// File: tb/tb_core_irq_controller_fsm.sv
// Directed bench for core_irq_controller_fsm: reset, CSR access, trap entry, mret,
// priority, cancellation, DONE flow, forced reset and PC wrap.
module tb_core_irq_controller_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control_signal;
  logic        end_condition, all_ready, ready_for_irq_handler;
  logic [2:0]  irq_lines;
  logic [31:0] pc_stage_2, next_pc;
  logic        redirect, mret_inst, write_csr;
  logic [11:0] csr_wr_addr, csr_rd_addr;
  logic [31:0] csr_wr_data, csr_rd_data;
  logic        enable_design, program_finished, irq_prep;
  logic [31:0] interrupt_vector_o, mepc_o, mcause_o;
  logic [2:0]  irq_ack_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_irq_controller_fsm dut (
    .clk                                    (clk),
    .reset                                  (reset),
    .control_signal                         (control_signal),
    .end_condition                          (end_condition),
    .all_ready                              (all_ready),
    .ready_for_irq_handler                  (ready_for_irq_handler),
    .irq_lines                              (irq_lines),
    .pc_stage_2                             (pc_stage_2),
    .nextPC_o                               (next_pc),
    .change_PC_condition_for_jump_or_branch (redirect),
    .mret_inst                              (mret_inst),
    .write_csr                              (write_csr),
    .csr_wr_addr                            (csr_wr_addr),
    .csr_rd_addr                            (csr_rd_addr),
    .csr_wr_data                            (csr_wr_data),
    .csr_rd_data                            (csr_rd_data),
    .enable_design                          (enable_design),
    .program_finished                       (program_finished),
    .irq_prep                               (irq_prep),
    .interrupt_vector_o                     (interrupt_vector_o),
    .mepc_o                                 (mepc_o),
    .mcause_o                               (mcause_o),
    .irq_ack_o                              (irq_ack_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    csr_rd_addr = addr;
    #1;
    chk(tag, csr_rd_data, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    write_csr   = 1'b1;
    csr_wr_addr = addr;
    csr_wr_data = data;
    step();
    write_csr   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; control_signal = '0; end_condition = 0; all_ready = 0;
    ready_for_irq_handler = 0; irq_lines = '0; pc_stage_2 = '0; next_pc = '0;
    redirect = 0; mret_inst = 0; write_csr = 0; csr_wr_addr = '0; csr_rd_addr = '0;
    csr_wr_data = '0;
    step();
    reset = 1'b0;
    chk("rst_enable", 32'(enable_design), 32'd0);
    chk("rst_finished", 32'(program_finished), 32'd0);
    chk("rst_prep", 32'(irq_prep), 32'd0);
    chk("rst_ack", 32'(irq_ack_o), 32'd0);
    chk("rst_mepc", mepc_o, 32'd0);
    chk("rst_mcause", mcause_o, 32'd0);
    rd(12'h300, "rst_mstatus", 32'd0);

    control_signal = 32'd1;
    step();
    control_signal = '0;
    chk("start_enable", 32'(enable_design), 32'd1);

    // mie masks to implemented bits; forwarding shows the masked value
    write_csr = 1'b1; csr_wr_addr = 12'h304; csr_wr_data = 32'hFFFF_FFFF;
    rd(12'h304, "mie_fwd", 32'h888);
    step();
    write_csr = 1'b0;
    rd(12'h304, "mie_mask", 32'h888);
    wr(12'h304, 32'h80);
    wr(12'h305, 32'h1001);
`ifdef IRQ_VECTORED_EN
    rd(12'h305, "mtvec_rd", 32'h1001);
`else
    rd(12'h305, "mtvec_rd", 32'h1000);
`endif
    wr(12'h300, 32'h8);
    rd(12'h300, "mstatus_wr", 32'h8);
    wr(12'h123, 32'hABCD);
    rd(12'h123, "unimpl_rd", 32'd0);
    wr(12'h344, 32'hFFFF_FFFF);
    rd(12'h344, "mip_ro", 32'd0);

    // Timer-line trap: line 1, pc 0x100, no redirect
    irq_lines = 3'b010; pc_stage_2 = 32'h100;
    rd(12'h344, "mip_live", 32'h80);
    step();
    chk("t1_prep", 32'(irq_prep), 32'd1);
    ready_for_irq_handler = 1'b1; irq_lines = '0;   // line drop must not cancel
    step();
    ready_for_irq_handler = 1'b0;
    chk("t1_mepc", mepc_o, 32'h104);
    chk("t1_mcause", mcause_o, 32'h8000_0007);
    chk("t1_ack", 32'(irq_ack_o), 32'h2);
    rd(12'h300, "t1_mstatus", 32'h80);
`ifdef IRQ_VECTORED_EN
    chk("t1_vector", interrupt_vector_o, 32'h101C);
`else
    chk("t1_vector", interrupt_vector_o, 32'h1000);
`endif
    step();
    chk("t1_ack_pulse", 32'(irq_ack_o), 32'd0);
    mret_inst = 1'b1;
    step();
    mret_inst = 1'b0;
    rd(12'h300, "mret1_mstatus", 32'h88);

    // Lines 0 and 2 pending: line 2 wins; redirect; same-edge mepc write loses
    wr(12'h304, 32'h888);
    irq_lines = 3'b101; pc_stage_2 = 32'h200; redirect = 1'b1; next_pc = 32'h400;
    step();
    chk("t2_prep", 32'(irq_prep), 32'd1);
    ready_for_irq_handler = 1'b1;
    wr(12'h341, 32'hDEAD_BEEF);
    ready_for_irq_handler = 1'b0; irq_lines = '0; redirect = 1'b0;
    chk("t2_mepc", mepc_o, 32'h400);
    chk("t2_mcause", mcause_o, 32'h8000_000B);
    chk("t2_ack", 32'(irq_ack_o), 32'h4);
`ifdef IRQ_VECTORED_EN
    chk("t2_vector", interrupt_vector_o, 32'h102C);
`else
    chk("t2_vector", interrupt_vector_o, 32'h1000);
`endif
    mret_inst = 1'b1;
    step();
    mret_inst = 1'b0;
    rd(12'h300, "mret2_mstatus", 32'h88);

    // reset_request in PARTIAL_IRQ cancels the trap
    irq_lines = 3'b010; pc_stage_2 = 32'h300;
    step();
    chk("c_prep", 32'(irq_prep), 32'd1);
    control_signal = 32'd2; ready_for_irq_handler = 1'b1;
    step();
    control_signal = '0; ready_for_irq_handler = 1'b0; irq_lines = '0;
    chk("c_prep_off", 32'(irq_prep), 32'd0);
    chk("c_ack", 32'(irq_ack_o), 32'd0);
    chk("c_enable", 32'(enable_design), 32'd1);
    chk("c_mepc", mepc_o, 32'h400);
    rd(12'h300, "c_mstatus", 32'h88);
    all_ready = 1'b1;
    step();
    all_ready = 1'b0;
    chk("c_idle", 32'(enable_design), 32'd0);

    // DONE flow
    control_signal = 32'd1;
    step();
    control_signal = '0; end_condition = 1'b1;
    step();
    end_condition = 1'b0;
    chk("d_finished", 32'(program_finished), 32'd1);
    step();
    chk("d_hold", 32'(program_finished), 32'd1);
    control_signal = 32'd2;
    step();
    control_signal = '0;
    chk("d_ffr_fin", 32'(program_finished), 32'd0);
    chk("d_ffr_en", 32'(enable_design), 32'd1);
    all_ready = 1'b1;
    step();
    all_ready = 1'b0;
    chk("d_idle", 32'(enable_design), 32'd0);

    // pc + 4 wraps, then forced FSM reset keeps CSRs
    control_signal = 32'd1;
    step();
    control_signal = '0; irq_lines = 3'b010; pc_stage_2 = 32'hFFFF_FFFC;
    step();
    ready_for_irq_handler = 1'b1; irq_lines = '0;
    step();
    ready_for_irq_handler = 1'b0;
    chk("w_mepc", mepc_o, 32'd0);
    chk("w_mcause", mcause_o, 32'h8000_0007);
    control_signal = 32'd4;
    step();
    control_signal = '0;
    chk("f_enable", 32'(enable_design), 32'd0);
    chk("f_ack", 32'(irq_ack_o), 32'd0);
    rd(12'h300, "f_mstatus", 32'h80);
    chk("f_mepc", mepc_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
